// File: rtl/cut_sequencer_if.sv
// Job-control and driver handshake bundle for cut_sequencer.
// slave = sequencer side, master = controller/driver side.
interface cut_sequencer_if #(
  parameter int CNT_W = 6
);
  logic             start_i;
  logic [CNT_W-1:0] num_cuts_i;
  logic             abort_i;
  logic             busy_o;
  logic             done_o;
  logic             fault_o;
  logic [CNT_W-1:0] cuts_done_o;
  logic             cut_o;
  logic             cut_end_i;
  logic             feed_o;
  logic             feed_done_i;

  modport slave (
    input  start_i, num_cuts_i, abort_i,
    input  cut_end_i, feed_done_i,
    output busy_o, done_o, fault_o,
    output cuts_done_o, cut_o, feed_o
  );

  modport master (
    output start_i, num_cuts_i, abort_i,
    output cut_end_i, feed_done_i,
    input  busy_o, done_o, fault_o,
    input  cuts_done_o, cut_o, feed_o
  );
endinterface

// File: rtl/cut_sequencer.sv
// Slicing-run controller: cut stroke, feed advance, settle gap, repeat.
// One shared timer serves as settle counter and CUT/FEED watchdog.
module cut_sequencer #(
  parameter int CNT_W       = 6,
  parameter int SETTLE_CYC  = 2_500_000,
  parameter int TIMEOUT_CYC = 150_000_000
) (
  input logic           clk,
  input logic           rst_n,
  cut_sequencer_if.slave bus
);
  localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYC - 1);
  localparam logic [31:0] SE_LAST = 32'(SETTLE_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CUT, S_FEED, S_SETTLE, S_DONE, S_FAULT
  } state_t;

  state_t           state, nxt;
  logic [31:0]      tmr;
  logic [CNT_W-1:0] num_q, cnt, cnt_p1;
  logic [2:0]       ce_s, fd_s;
  logic             ce_ev, fd_ev;
  logic             accept, cnt_inc, wd_exp, timing;
  logic             o_cut, o_feed, o_done, o_fault, o_busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ce_s <= '0;
      fd_s <= '0;
    end else begin
      ce_s <= {ce_s[1:0], bus.cut_end_i};
      fd_s <= {fd_s[1:0], bus.feed_done_i};
    end
  end

  assign ce_ev  = ce_s[1] & ~ce_s[2];
  assign fd_ev  = fd_s[1] & ~fd_s[2];
  assign cnt_p1 = cnt + 1'b1;
  assign timing = (state == S_CUT) || (state == S_FEED)
               || (state == S_SETTLE);
  assign wd_exp = ((state == S_CUT) || (state == S_FEED))
               && (tmr == TO_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      tmr   <= '0;
      num_q <= '0;
      cnt   <= '0;
    end else begin
      state <= nxt;
      if (nxt != state || !timing)
        tmr <= '0;
      else
        tmr <= tmr + 32'd1;
      if (accept) begin
        num_q <= bus.num_cuts_i;
        cnt   <= '0;
      end else if (cnt_inc) begin
        cnt <= cnt_p1;
      end
    end
  end

  // abort > watchdog > handshake event > start
  always_comb begin
    nxt     = state;
    accept  = 1'b0;
    cnt_inc = 1'b0;
    if (bus.abort_i) begin
      nxt = S_IDLE;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (bus.start_i) begin
            accept = 1'b1;
            nxt    = (bus.num_cuts_i == '0) ? S_DONE : S_CUT;
          end
        end
        S_CUT: begin
          if (wd_exp) begin
            nxt = S_FAULT;
          end else if (ce_ev) begin
            cnt_inc = 1'b1;
            nxt     = (cnt_p1 == num_q) ? S_DONE : S_FEED;
          end
        end
        S_FEED: begin
          if (wd_exp)
            nxt = S_FAULT;
          else if (fd_ev)
            nxt = S_SETTLE;
        end
        S_SETTLE: begin
          if (tmr == SE_LAST)
            nxt = S_CUT;
        end
        S_DONE:  nxt = S_IDLE;
        S_FAULT: nxt = S_FAULT;
        default: nxt = S_IDLE;
      endcase
    end
  end

  always_comb begin
    o_cut   = (state == S_CUT);
    o_feed  = (state == S_FEED);
    o_done  = (state == S_DONE);
    o_fault = (state == S_FAULT);
    o_busy  = (state != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.cut_o   <= 1'b0;
      bus.feed_o  <= 1'b0;
      bus.done_o  <= 1'b0;
      bus.fault_o <= 1'b0;
      bus.busy_o  <= 1'b0;
    end else begin
      bus.cut_o   <= o_cut;
      bus.feed_o  <= o_feed;
      bus.done_o  <= o_done;
      bus.fault_o <= o_fault;
      bus.busy_o  <= o_busy;
    end
  end

  assign bus.cuts_done_o = cnt;
endmodule

// File: tb/tb_cut_sequencer.sv
// Directed bench for cut_sequencer with behavioural cut and feed drivers.
module tb_cut_sequencer;
  localparam int CNT_W = 6;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cut_sequencer_if #(.CNT_W(CNT_W)) bus();

  cut_sequencer #(
    .CNT_W(CNT_W), .SETTLE_CYC(50), .TIMEOUT_CYC(5000)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int cut_rise, feed_rise, done_hi;
  int win_len, win_min, win_max;
  bit pc, pf;
  bit model_en = 1'b1;
  int pulse_len = 200;

  always @(posedge clk) cyc <= cyc + 1;

  // cut driver: cut_end rises 1000 clk after it sees cut_i rise
  int ccnt, ecnt, fcnt, fhold;
  logic cut_q, feed_q;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ccnt <= 0; ecnt <= 0; fcnt <= 0; fhold <= 0;
      cut_q <= 1'b0; feed_q <= 1'b0;
      bus.cut_end_i <= 1'b0;
      bus.feed_done_i <= 1'b0;
    end else begin
      cut_q  <= bus.cut_o;
      feed_q <= bus.feed_o;
      if (ecnt > 1) ecnt <= ecnt - 1;
      else if (ecnt == 1) begin ecnt <= 0; bus.cut_end_i <= 1'b0; end
      if (ccnt == 1000) begin
        ccnt <= 0;
        if (model_en) begin bus.cut_end_i <= 1'b1; ecnt <= pulse_len; end
      end else if (ccnt != 0) ccnt <= ccnt + 1;
      if (bus.cut_o && !cut_q) ccnt <= 1;
      if (fhold > 1) fhold <= fhold - 1;
      else if (fhold == 1) begin fhold <= 0; bus.feed_done_i <= 1'b0; end
      if (fcnt == 20) begin
        fcnt <= 0; bus.feed_done_i <= 1'b1; fhold <= 3;
      end else if (fcnt != 0) fcnt <= fcnt + 1;
      if (bus.feed_o && !feed_q) fcnt <= 1;
    end
  end

  always @(negedge clk) begin
    if (bus.cut_o && !pc) cut_rise++;
    if (bus.feed_o && !pf) feed_rise++;
    if (bus.done_o) done_hi++;
    if (bus.cut_o) win_len++;
    if (!bus.cut_o && pc) begin
      if (win_len < win_min) win_min = win_len;
      if (win_len > win_max) win_max = win_len;
      win_len = 0;
    end
    pc = bus.cut_o;
    pf = bus.feed_o;
  end

  task automatic clr();
    cut_rise = 0; feed_rise = 0; done_hi = 0;
    win_min = 1 << 30; win_max = 0;
  endtask

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic start_job(input int n);
    @(negedge clk);
    bus.num_cuts_i = CNT_W'(n);
    bus.start_i = 1'b1;
    @(negedge clk);
    bus.start_i = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    int k = 0;
    while (!bus.done_o && k < budget) begin @(negedge clk); k++; end
    ok = bus.done_o;
  endtask

  task automatic wait_cut(input int budget, output bit ok);
    int k = 0;
    while (!bus.cut_o && k < budget) begin @(negedge clk); k++; end
    ok = bus.cut_o;
  endtask

  task automatic pulse_abort();
    @(negedge clk); bus.abort_i = 1'b1;
    @(negedge clk); bus.abort_i = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    bus.start_i = 1'b0; bus.abort_i = 1'b0; bus.num_cuts_i = '0;
    rst_n = 1'b0;
    clks(3);
    rst_n = 1'b1;
    clks(2);
    n_cmp++; if (bus.busy_o !== 1'b0) begin n_bad++; $display("FAIL rst_busy got %b want 0", bus.busy_o); end
    n_cmp++; if (bus.done_o !== 1'b0) begin n_bad++; $display("FAIL rst_done got %b want 0", bus.done_o); end
    n_cmp++; if (bus.fault_o !== 1'b0) begin n_bad++; $display("FAIL rst_fault got %b want 0", bus.fault_o); end
    n_cmp++; if (bus.cut_o !== 1'b0) begin n_bad++; $display("FAIL rst_cut got %b want 0", bus.cut_o); end
    n_cmp++; if (bus.feed_o !== 1'b0) begin n_bad++; $display("FAIL rst_feed got %b want 0", bus.feed_o); end
    n_cmp++; if (bus.cuts_done_o !== '0) begin n_bad++; $display("FAIL rst_cuts got %0d want 0", bus.cuts_done_o); end
  endtask

  task automatic test_job3();
    bit ok;
    clr();
    start_job(3);
    wait_done(20000, ok);
    clks(3);
    n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL job3_done got %b want 1", ok); end
    n_cmp++; if (cut_rise != 3) begin n_bad++; $display("FAIL job3_cut_win got %0d want 3", cut_rise); end
    n_cmp++; if (feed_rise != 2) begin n_bad++; $display("FAIL job3_feed_win got %0d want 2", feed_rise); end
    n_cmp++; if (done_hi != 1) begin n_bad++; $display("FAIL job3_done_cyc got %0d want 1", done_hi); end
    n_cmp++; if (bus.cuts_done_o !== 6'd3) begin n_bad++; $display("FAIL job3_cuts got %0d want 3", bus.cuts_done_o); end
    n_cmp++; if (bus.busy_o !== 1'b0) begin n_bad++; $display("FAIL job3_busy got %b want 0", bus.busy_o); end
    n_cmp++; if (win_min != 1005 || win_max != 1005) begin n_bad++; $display("FAIL job3_cut_len got %0d..%0d want 1005", win_min, win_max); end
  endtask

  task automatic test_zero();
    clr();
    @(negedge clk);
    bus.num_cuts_i = '0; bus.start_i = 1'b1;
    @(negedge clk);
    bus.start_i = 1'b0;
    n_cmp++; if (bus.done_o !== 1'b0) begin n_bad++; $display("FAIL zero_done_c1 got %b want 0", bus.done_o); end
    @(negedge clk);
    n_cmp++; if (bus.done_o !== 1'b1) begin n_bad++; $display("FAIL zero_done_c2 got %b want 1", bus.done_o); end
    @(negedge clk);
    n_cmp++; if (bus.done_o !== 1'b0) begin n_bad++; $display("FAIL zero_done_c3 got %b want 0", bus.done_o); end
    clks(3);
    n_cmp++; if (done_hi != 1) begin n_bad++; $display("FAIL zero_done_cyc got %0d want 1", done_hi); end
    n_cmp++; if (cut_rise + feed_rise != 0) begin n_bad++; $display("FAIL zero_drives got %0d want 0", cut_rise + feed_rise); end
    n_cmp++; if (bus.cuts_done_o !== '0) begin n_bad++; $display("FAIL zero_cuts got %0d want 0", bus.cuts_done_o); end
  endtask

  task automatic test_fault();
    bit ok;
    int t0, t1, k;
    model_en = 1'b0;
    clr();
    start_job(2);
    wait_cut(20, ok);
    t0 = cyc;
    k = 0;
    while (!bus.fault_o && k < 6000) begin @(negedge clk); k++; end
    t1 = cyc;
    n_cmp++; if (bus.fault_o !== 1'b1) begin n_bad++; $display("FAIL flt_set got %b want 1", bus.fault_o); end
    n_cmp++; if (t1 - t0 != 5000) begin n_bad++; $display("FAIL flt_delay got %0d want 5000", t1 - t0); end
    n_cmp++; if (bus.cut_o !== 1'b0) begin n_bad++; $display("FAIL flt_cut got %b want 0", bus.cut_o); end
    clks(10);
    n_cmp++; if (bus.fault_o !== 1'b1 || bus.busy_o !== 1'b1) begin n_bad++; $display("FAIL flt_hold got %b%b want 11", bus.fault_o, bus.busy_o); end
    pulse_abort();
    n_cmp++; if (bus.fault_o !== 1'b0) begin n_bad++; $display("FAIL flt_clear got %b want 0", bus.fault_o); end
    n_cmp++; if (bus.busy_o !== 1'b0) begin n_bad++; $display("FAIL flt_busy got %b want 0", bus.busy_o); end
    model_en = 1'b1;
    clks(5);
  endtask

  task automatic test_abort();
    int k = 0;
    clr();
    start_job(4);
    while (feed_rise < 2 && k < 10000) begin @(negedge clk); k++; end
    n_cmp++; if (bus.feed_o !== 1'b1) begin n_bad++; $display("FAIL abt_in_feed got %b want 1", bus.feed_o); end
    pulse_abort();
    n_cmp++; if (bus.feed_o !== 1'b0) begin n_bad++; $display("FAIL abt_feed got %b want 0", bus.feed_o); end
    n_cmp++; if (bus.busy_o !== 1'b0) begin n_bad++; $display("FAIL abt_busy got %b want 0", bus.busy_o); end
    clks(3000);
    n_cmp++; if (done_hi != 0) begin n_bad++; $display("FAIL abt_no_done got %0d want 0", done_hi); end
    n_cmp++; if (bus.cuts_done_o !== 6'd2) begin n_bad++; $display("FAIL abt_cuts got %0d want 2", bus.cuts_done_o); end
    n_cmp++; if (cut_rise != 2) begin n_bad++; $display("FAIL abt_cut_win got %0d want 2", cut_rise); end
  endtask

  task automatic test_misc();
    bit ok;
    pulse_len = 500;
    clr();
    start_job(2);
    wait_cut(20, ok);
    repeat (3) begin
      @(negedge clk); bus.num_cuts_i = 6'd5; bus.start_i = 1'b1;
      @(negedge clk); bus.start_i = 1'b0;
      clks(5);
    end
    wait_done(20000, ok);
    clks(3);
    n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL msc_done got %b want 1", ok); end
    n_cmp++; if (bus.cuts_done_o !== 6'd2) begin n_bad++; $display("FAIL msc_cuts got %0d want 2", bus.cuts_done_o); end
    n_cmp++; if (cut_rise != 2 || feed_rise != 1) begin n_bad++; $display("FAIL msc_windows got %0d/%0d want 2/1", cut_rise, feed_rise); end
    n_cmp++; if (win_min != 1005 || win_max != 1005) begin n_bad++; $display("FAIL msc_long_end got %0d..%0d want 1005", win_min, win_max); end
    pulse_len = 200;
    clks(600);
    clr();
    @(negedge clk);
    bus.num_cuts_i = 6'd1; bus.start_i = 1'b1; bus.abort_i = 1'b1;
    @(negedge clk);
    bus.start_i = 1'b0; bus.abort_i = 1'b0;
    clks(3);
    n_cmp++; if (bus.busy_o !== 1'b0) begin n_bad++; $display("FAIL sa_busy got %b want 0", bus.busy_o); end
    clks(1100);
    n_cmp++; if (cut_rise != 0 || done_hi != 0) begin n_bad++; $display("FAIL sa_idle got %0d/%0d want 0/0", cut_rise, done_hi); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int k = 0;
    clr();
    start_job(3);
    while (!(bus.cuts_done_o == 6'd1 && bus.cut_o) && k < 5000) begin @(negedge clk); k++; end
    n_cmp++; if (bus.cut_o !== 1'b1) begin n_bad++; $display("FAIL rm_in_cut got %b want 1", bus.cut_o); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (bus.cut_o !== 1'b0 || bus.busy_o !== 1'b0) begin n_bad++; $display("FAIL rm_drop got %b%b want 00", bus.cut_o, bus.busy_o); end
    n_cmp++; if (bus.cuts_done_o !== '0) begin n_bad++; $display("FAIL rm_cuts got %0d want 0", bus.cuts_done_o); end
    clks(3);
    rst_n = 1'b1;
    clks(3);
    clr();
    start_job(1);
    wait_done(5000, ok);
    clks(3);
    n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL rm_new_done got %b want 1", ok); end
    n_cmp++; if (bus.cuts_done_o !== 6'd1) begin n_bad++; $display("FAIL rm_new_cuts got %0d want 1", bus.cuts_done_o); end
    n_cmp++; if (cut_rise != 1 || feed_rise != 0 || done_hi != 1) begin n_bad++; $display("FAIL rm_new_win got %0d/%0d/%0d want 1/0/1", cut_rise, feed_rise, done_hi); end
  endtask

  initial begin
    clr();
    test_reset();
    test_job3();
    test_zero();
    test_fault();
    test_abort();
    test_misc();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
